// File: rtl/uart_pkg.sv
// Shared UART constants used by the RX buffer and the rest of the UART slice.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_FIFO_DEPTH_DEF = 16;
    // clk cycles per UART bit period
    localparam int UART_BAUD_DIV       = 868;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Produces exactly one clk-wide pulse per rising edge of the asynchronous level,
// two clk edges after the edge is first sampled. Reusable for other UART crossings.
module uart_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    // synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign pulse = s2_reg & ~s3_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Captures one byte per rx_ready rising edge into a first-word-fall-through FIFO
// and presents it on a valid/ready interface. Dropped bytes set a sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_FIFO_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_ready,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W:0]        level,
    output logic                   full,
    output logic                   overrun,
    input  logic                   flush,
    input  logic                   ovr_clr
);

    // Storage is small, so it is read asynchronously to give fall-through
    // behaviour without an output staging register.
    logic [UART_DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr_reg;
    logic [ADDR_W:0] rd_ptr_reg;
    logic [ADDR_W:0] wr_ptr_next;
    logic [ADDR_W:0] rd_ptr_next;
    logic            overrun_reg;
    logic            overrun_next;

    logic wr_stb;
    logic empty;
    logic pop;
    logic wr_en;
    logic drop;

    uart_sync_edge u_rx_ready_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (rx_ready),
        .pulse (wr_stb)
    );

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr_reg[ADDR_W-1:0]];
    assign overrun   = overrun_reg;

    // flush overrides everything; a full FIFO still accepts a byte if a pop frees a slot
    assign pop   = out_valid & out_ready & ~flush;
    assign wr_en = wr_stb & ~flush & (~full | pop);
    assign drop  = wr_stb & ~flush & full & ~pop;

    // next-state for pointers and the sticky overrun flag
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        overrun_next = overrun_reg;
        if (flush) begin
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
            overrun_next = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            // a drop on the same edge as ovr_clr keeps the flag set
            if (drop) begin
                overrun_next = 1'b1;
            end else if (ovr_clr) begin
                overrun_next = 1'b0;
            end
        end
    end

    // pointer and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            overrun_reg <= overrun_next;
        end
    end

    // byte storage; not reset, validity comes only from the pointers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          full;
    logic          overrun;
    logic          flush;
    logic          ovr_clr;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] q[$];
    bit         ovr_m;
    bit         prev_rx;
    int         sched[$];
    int         cyc;
    bit         rnd_ready;
    bit         rnd_ctl;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .overrun   (overrun),
        .flush     (flush),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overrun", 32'(overrun), 32'(ovr_m));
        if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    endtask

    task automatic model_reset();
        q.delete();
        sched.delete();
        ovr_m   = 1'b0;
        prev_rx = 1'b0;
    endtask

    // one clock edge: update the model from the inputs seen at the edge, then compare
    task automatic step();
        bit wr, pop, drop;
        @(posedge clk);
        cyc++;
        // a rising edge of rx_ready first seen at edge k writes at edge k+2
        if (rx_ready && !prev_rx) sched.push_back(cyc + 2);
        prev_rx = rx_ready;
        wr = 1'b0;
        if (sched.size() > 0 && sched[0] == cyc) begin
            wr = 1'b1;
            void'(sched.pop_front());
        end
        pop = out_ready && (q.size() > 0);
        if (flush) begin
            q.delete();
            ovr_m = 1'b0;
        end else begin
            drop = wr && (q.size() == DEPTH) && !pop;
            if (pop) void'(q.pop_front());
            if (wr && !drop) q.push_back(rx_data);
            if (drop) ovr_m = 1'b1;
            else if (ovr_clr) ovr_m = 1'b0;
        end
        #1;
        check_outputs();
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        if (rnd_ctl) begin
            flush   = ($urandom_range(0, 59) == 0);
            ovr_clr = ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic pulse(input logic [7:0] d, input int hi, input int lo);
        rx_data  = d;
        rx_ready = 1'b1;
        repeat (hi) step();
        rx_ready = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        cyc = 0; rnd_ready = 0; rnd_ctl = 0;
        rst = 1'b0; rx_data = '0; rx_ready = 1'b0; out_ready = 1'b0;
        flush = 1'b0; ovr_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        // long rx_ready level gives a single write
        pulse(8'hA5, 868, 3);
        chk("single_write_level", 32'(level), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0; step();

        // fill, overflow drop, drain in order
        for (int i = 0; i < 16; i++) pulse(8'(i), 3, 3);
        pulse(8'hFF, 3, 3);
        chk("overflow_flag", 32'(overrun), 32'd1);
        out_ready = 1'b1; repeat (17) step(); out_ready = 1'b0;
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0; step();

        // full FIFO: write coincides with pop
        for (int i = 0; i < 16; i++) pulse(8'(8'h40 + i), 3, 3);
        rx_data = 8'h77; rx_ready = 1'b1;
        step(); step();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        step(); rx_ready = 1'b0; repeat (3) step();
        chk("full_wr_pop_ovr", 32'(overrun), 32'd0);

        // drop on the same edge as ovr_clr: set wins
        rx_data = 8'h88; rx_ready = 1'b1;
        step(); step();
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        rx_ready = 1'b0; repeat (3) step();
        chk("drop_vs_clr", 32'(overrun), 32'd1);

        // flush at level 5
        out_ready = 1'b1; repeat (11) step(); out_ready = 1'b0;
        chk("pre_flush_level", 32'(level), 32'd5);
        flush = 1'b1; step(); flush = 1'b0; step();

        // level 1: write and pop on the same edge
        pulse(8'h11, 3, 3);
        rx_data = 8'h3C; rx_ready = 1'b1;
        step(); step();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("no_bubble_data", 32'(out_data), 32'h3C);
        rx_ready = 1'b0; repeat (3) step();
        out_ready = 1'b1; step(); out_ready = 1'b0; step();

        // asynchronous reset with data stored and rx_ready high
        for (int i = 0; i < 7; i++) pulse(8'($urandom), 3, 3);
        rx_data = 8'h99; rx_ready = 1'b1; step();
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        rx_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1; check_outputs();
        end
        rst = 1'b1;

        // streaming writes with immediate pops, pointers wrap
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) pulse(8'($urandom), 2, 2);
        out_ready = 1'b0;

        // randomized traffic
        rnd_ready = 1; rnd_ctl = 1;
        for (int i = 0; i < 300; i++)
            pulse(8'($urandom), $urandom_range(2, 6), $urandom_range(2, 6));
        rnd_ready = 0; rnd_ctl = 0;
        flush = 1'b0; ovr_clr = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
